// File: rtl/fifo_wr_ptr_pkg.sv
// fifo_wr_ptr_pkg
//  Shared definitions for the dual-clock FIFO pointer stages (write side now,
//  read side later).
//  - ptr_w():       pointer width for a given RAM address width
//  - gray_is_full(): Gray-domain full compare. The FIFO is full when the write
//                    pointer equals the read pointer with its two MSBs
//                    inverted: binary pointers differ by exactly the depth.
//  The compare works on 32-bit zero-extended operands so one function serves
//  any pointer width up to 32 bits.
package fifo_wr_ptr_pkg;

   function automatic int unsigned ptr_w(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic logic gray_is_full(input logic [31:0] wr_gray,
                                         input logic [31:0] rd_gray,
                                         input int unsigned pw);
      logic [31:0] top2;
      logic [31:0] mask;
      top2 = 32'd3 << (pw - 2);
      mask = (32'd1 << pw) - 32'd1;
      return ((wr_gray ^ rd_gray ^ top2) & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/bin2gray.sv
// bin2gray
//  Binary to reflected-Gray conversion, purely combinational.
//  Ports:
//   bin_i   in   DATA_WIDTH   binary value
//   gray_o  out  DATA_WIDTH   Gray encoding of bin_i
module bin2gray #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0] bin_i,
   output logic [DATA_WIDTH-1:0] gray_o
);

   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_wr_ptr.sv
// fifo_wr_ptr
//  Write-side pointer stage of a dual-clock FIFO. Holds the binary write
//  pointer plus a registered Gray copy for the read domain, synchronises the
//  read domain's Gray pointer and produces a registered full flag.
//  Optional build macro: FIFO_WR_LEVEL_EN adds a write-side fill level and an
//  almost-full flag; without it those outputs are tied to 0.
//  Ports:
//   clk             in   1     write-domain clock
//   rst_n           in   1     asynchronous active-low reset
//   wr_en           in   1     producer write request
//   rd_ptr_gray_in  in   A+1   read pointer (Gray) from the read domain
//   wr_push         out  1     RAM write enable
//   wr_addr         out  A     RAM write address
//   wr_ptr_gray     out  A+1   registered Gray write pointer
//   wr_full         out  1     FIFO full (registered)
//   wr_overflow     out  1     one-cycle pulse for a write attempted while full
//   wr_level        out  A+1   fill level seen by the write side
//   wr_almost_full  out  1     wr_level >= ALMOST_FULL_THRESH
module fifo_wr_ptr
   import fifo_wr_ptr_pkg::*;
#(
   parameter int ADDR_WIDTH         = 4,
   parameter int SYNC_STAGES        = 2,
   parameter int ALMOST_FULL_THRESH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_in,
   output logic                  wr_push,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray,
   output logic                  wr_full,
   output logic                  wr_overflow,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  wr_almost_full
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   if (ADDR_WIDTH < 2 || SYNC_STAGES < 2 ||
       ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_param
      $error("fifo_wr_ptr: illegal parameter combination");
   end

   logic                                push;
   logic [PTR_W-1:0]                    next_bin;
   logic [PTR_W-1:0]                    next_gray;
   logic [PTR_W-1:0]                    rd_sync;

   logic [PTR_W-1:0]                    wr_ptr_bin_q,  wr_ptr_bin_d;
   logic [PTR_W-1:0]                    wr_ptr_gray_q, wr_ptr_gray_d;
   logic [SYNC_STAGES-1:0][PTR_W-1:0]   sync_q,        sync_d;
   logic                                wr_full_q,     wr_full_d;
   logic                                wr_overflow_q, wr_overflow_d;
   logic [PTR_W-1:0]                    wr_level_q,    wr_level_d;
   logic                                wr_af_q,       wr_af_d;

   bin2gray #(.DATA_WIDTH(PTR_W)) u_bin2gray (
      .bin_i  (next_bin),
      .gray_o (next_gray)
   );

   assign rd_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      // rst_n gate keeps the RAM write enable quiet while reset is held
      push          = wr_en & ~wr_full_q & rst_n;
      next_bin      = wr_ptr_bin_q + PTR_W'(push);
      wr_ptr_bin_d  = next_bin;
      // Loaded alongside the binary pointer, so one bit flips per push
      wr_ptr_gray_d = next_gray;
      // Plain flop chain; nothing may sit between synchroniser stages
      sync_d        = sync_q;
      sync_d[0]     = rd_ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      // Next pointer vs current synced read pointer: full raises on the
      // filling push itself, and clears only once the read move is seen
      wr_full_d     = gray_is_full(32'(next_gray), 32'(rd_sync), PTR_W);
      wr_overflow_d = wr_en & wr_full_q;
   end

`ifdef FIFO_WR_LEVEL_EN
   logic [PTR_W-1:0] rd_bin_sync;

   // Gray to binary: bit i is the XOR of all Gray bits at or above i
   for (genvar i = 0; i < PTR_W; i++) begin : g_gray2bin
      assign rd_bin_sync[i] = ^rd_sync[PTR_W-1:i];
   end

   always_comb begin
      wr_level_d = next_bin - rd_bin_sync;
      wr_af_d    = (wr_level_d >= PTR_W'(ALMOST_FULL_THRESH));
   end
`else
   always_comb begin
      wr_level_d = '0;
      wr_af_d    = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_bin_q  <= '0;
         wr_ptr_gray_q <= '0;
         sync_q        <= '0;
         wr_full_q     <= 1'b0;
         wr_overflow_q <= 1'b0;
         wr_level_q    <= '0;
         wr_af_q       <= 1'b0;
      end else begin
         wr_ptr_bin_q  <= wr_ptr_bin_d;
         wr_ptr_gray_q <= wr_ptr_gray_d;
         sync_q        <= sync_d;
         wr_full_q     <= wr_full_d;
         wr_overflow_q <= wr_overflow_d;
         wr_level_q    <= wr_level_d;
         wr_af_q       <= wr_af_d;
      end
   end

   assign wr_push        = push;
   assign wr_addr        = wr_ptr_bin_q[ADDR_WIDTH-1:0];
   assign wr_ptr_gray    = wr_ptr_gray_q;
   assign wr_full        = wr_full_q;
   assign wr_overflow    = wr_overflow_q;
   assign wr_level       = wr_level_q;
   assign wr_almost_full = wr_af_q;

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// tb_fifo_wr_ptr
//  Directed bench for fifo_wr_ptr (ADDR_WIDTH=4, SYNC_STAGES=2, THRESH=12).
//  A reference model tracks the write count, the read count seen through a
//  two-cycle synchroniser and the resulting occupancy in plain integers; the
//  outputs are compared against it on every falling edge. Literal checks pin
//  key values of the directed scenarios.
module tb_fifo_wr_ptr;

   localparam int A  = 4;
   localparam int PW = A + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [PW-1:0] rd_ptr_gray_in;
   logic          wr_push;
   logic [A-1:0]  wr_addr;
   logic [PW-1:0] wr_ptr_gray;
   logic          wr_full;
   logic          wr_overflow;
   logic [PW-1:0] wr_level;
   logic          wr_almost_full;

   int errors = 0;
   int checks = 0;
   int rd_bin = 0;

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   assign rd_ptr_gray_in = to_gray(rd_bin);

   fifo_wr_ptr #(.ADDR_WIDTH(A), .SYNC_STAGES(2), .ALMOST_FULL_THRESH(12)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_en          (wr_en),
      .rd_ptr_gray_in (rd_ptr_gray_in),
      .wr_push        (wr_push),
      .wr_addr        (wr_addr),
      .wr_ptr_gray    (wr_ptr_gray),
      .wr_full        (wr_full),
      .wr_overflow    (wr_overflow),
      .wr_level       (wr_level),
      .wr_almost_full (wr_almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts modulo 2*depth, occupancy by subtraction
   int m_wr = 0, m_s0 = 0, m_s1 = 0, m_lvl = 0;
   bit m_full = 0, m_ovf = 0, m_af = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wr = 0; m_s0 = 0; m_s1 = 0; m_lvl = 0;
         m_full = 0; m_ovf = 0; m_af = 0;
      end else begin : model_step
         int occ;
         bit p;
         p      = wr_en && !m_full;
         m_ovf  = wr_en && m_full;
         m_wr   = (m_wr + int'(p)) % 32;
         occ    = (m_wr - m_s1 + 32) % 32;
         m_full = (occ == 16);
         m_lvl  = occ;
         m_af   = (occ >= 12);
         m_s1   = m_s0;
         m_s0   = rd_bin;
      end
   end

   always @(negedge clk) begin
      chk("push",     32'(wr_push),     32'(rst_n && wr_en && !m_full));
      chk("addr",     32'(wr_addr),     32'(m_wr % 16));
      chk("gray",     32'(wr_ptr_gray), 32'(to_gray(m_wr)));
      chk("full",     32'(wr_full),     32'(m_full));
      chk("overflow", 32'(wr_overflow), 32'(m_ovf));
`ifdef FIFO_WR_LEVEL_EN
      chk("level",    32'(wr_level),       32'(m_lvl));
      chk("afull",    32'(wr_almost_full), 32'(m_af));
`else
      chk("level",    32'(wr_level),       32'd0);
      chk("afull",    32'(wr_almost_full), 32'd0);
`endif
   end

   task automatic step(input bit en);
      wr_en = en;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_push"},  32'(wr_push),        32'd0);
      chk({tag, "_addr"},  32'(wr_addr),        32'd0);
      chk({tag, "_gray"},  32'(wr_ptr_gray),    32'd0);
      chk({tag, "_full"},  32'(wr_full),        32'd0);
      chk({tag, "_ovf"},   32'(wr_overflow),    32'd0);
      chk({tag, "_level"}, 32'(wr_level),       32'd0);
      chk({tag, "_af"},    32'(wr_almost_full), 32'd0);
   endtask

   task automatic reset_both();
      @(negedge clk); #1;
      rst_n = 1'b0; wr_en = 1'b0; rd_bin = 0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      #1;
   endtask

   logic [PW-1:0] prev_gray;

   initial begin
      // 1: reset held with random requests
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk_all_zero("rst_hold");
      end
      @(negedge clk); #1;
      rst_n = 1'b1; wr_en = 1'b0;
      #1;
      chk("rel_addr", 32'(wr_addr), 32'd0);
      chk("rel_full", 32'(wr_full), 32'd0);

      // 2: fill with read pointer at 0
      for (int i = 0; i < 16; i++) begin
         if (i < 15) step(1);
         else begin
            step(1);
            chk("fill_full", 32'(wr_full), 32'd1);
         end
         if (i == 14) chk("fill_not_yet_full", 32'(wr_full), 32'd0);
      end
      chk("fill_gray", 32'(wr_ptr_gray), 32'b11000);
      chk("fill_addr", 32'(wr_addr), 32'd0);
      chk("fill_push_blocked", 32'(wr_push), 32'd0);

      // 3: writes while full
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("ovf_pulse", 32'(wr_overflow), 32'd1);
         chk("ovf_gray",  32'(wr_ptr_gray), 32'b11000);
         chk("ovf_addr",  32'(wr_addr), 32'd0);
      end
      step(0);
      chk("ovf_end", 32'(wr_overflow), 32'd0);

      // 4: one read frees a slot; visible after three edges
      rd_bin = 1;
      step(0); chk("free_e1", 32'(wr_full), 32'd1);
      step(0); chk("free_e2", 32'(wr_full), 32'd1);
      step(0); chk("free_e3", 32'(wr_full), 32'd0);
      wr_en = 1'b1; #1;
      chk("free_push", 32'(wr_push), 32'd1);
      chk("free_addr", 32'(wr_addr), 32'd0);
      step(1);
      chk("refill_full", 32'(wr_full), 32'd1);
      wr_en = 1'b0;

      // 5: 40 pushes with the reader keeping up; pointer wraps
      reset_both();
      for (int i = 1; i <= 40; i++) begin
         prev_gray = wr_ptr_gray;
         rd_bin = (i - 1) % 32;
         step(1);
         chk("wrap_1bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
         chk("wrap_nofull", 32'(wr_full), 32'd0);
         if (i == 31) chk("wrap_g31", 32'(wr_ptr_gray), 32'b10000);
         if (i == 32) chk("wrap_g32", 32'(wr_ptr_gray), 32'b00000);
      end
      wr_en = 1'b0;

      // 6: level/almost-full, then reset mid-burst
      reset_both();
      for (int i = 0; i < 12; i++) step(1);
`ifdef FIFO_WR_LEVEL_EN
      chk("lvl12",  32'(wr_level), 32'd12);
      chk("af12",   32'(wr_almost_full), 32'd1);
`else
      chk("lvl_off", 32'(wr_level), 32'd0);
      chk("af_off",  32'(wr_almost_full), 32'd0);
`endif
      chk("lvl_addr", 32'(wr_addr), 32'd12);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(negedge clk); #1;
      rst_n = 1'b1; wr_en = 1'b0;
      step(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
